multiplier_taint_track_limb: RTL and testbench

Constant-time sequential shift-add multiplier with limb-granular taint tracking and an explicit signed/unsigned mode. It succeeds the word-level-taint multiplier: it adds a start/ready handshake, a fixed-cycle signed correction step, and per-limb product taint in place of a single taint bit per word. It sits in the state-reconvergence test designs as the drop-in multiply unit. Latency is independent of operand values, operand taint and mode.

---
 rtl/multiplier_taint_track_limb.sv | 185 ++++++++++++++++++
 tb/tb_multiplier_taint_track_limb.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_taint_track_limb.sv
// rtl/multiplier_taint_track_limb.sv - constant-time shift-add multiplier with per-limb taint tracking
module multiplier_taint_track_limb #(
    parameter int WIDTH = 64,
    parameter int LIMB  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      start_t,
    input  logic                      signed_mode,
    input  logic [WIDTH-1:0]          multiplicand,
    input  logic [WIDTH/LIMB-1:0]     multiplicand_t,
    input  logic [WIDTH-1:0]          multiplier,
    input  logic [WIDTH/LIMB-1:0]     multiplier_t,
    output logic                      ready,
    output logic                      ready_t,
    output logic [2*WIDTH-1:0]        product,
    output logic [2*(WIDTH/LIMB)-1:0] product_t,
    output logic                      productDone,
    output logic                      productDone_t
);

    localparam int NLIMB = WIDTH / LIMB;
    localparam int CW    = $clog2(WIDTH);

    generate
        if (WIDTH < 2 || (WIDTH % LIMB) != 0) begin : g_bad_params
            $error("multiplier_taint_track_limb: WIDTH must be >= 2 and a multiple of LIMB");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_CORR,
        S_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       a_q, a_d;
    logic [WIDTH-1:0]       b_q, b_d;
    logic [WIDTH-1:0]       mult_q, mult_d;
    logic                   mode_q, mode_d;
    logic [NLIMB-1:0]       a_t_q, a_t_d;
    logic [NLIMB-1:0]       b_t_q, b_t_d;
    logic                   ctl_t_q, ctl_t_d;
    logic [2*WIDTH-1:0]     sum_q, sum_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2*WIDTH-1:0]     product_q, product_d;
    logic [2*NLIMB-1:0]     product_t_q, product_t_d;

    logic                   accept;
    logic [WIDTH-1:0]       addend;
    logic [WIDTH:0]         upper_sum;
    logic [2*WIDTH-1:0]     step_sum;
    logic [2*WIDTH-1:0]     corr_a;
    logic [2*WIDTH-1:0]     corr_b;
    logic [2*WIDTH-1:0]     corr_sum;
    logic [2*NLIMB-1:0]     limb_taint;
    logic                   any_t;

    assign ready         = (state_q == S_IDLE) || (state_q == S_DONE);
    assign accept        = ready && start;
    assign productDone   = (state_q == S_DONE);
    assign ready_t       = ctl_t_q;
    assign productDone_t = ctl_t_q;
    assign product       = product_q;
    assign product_t     = product_t_q;

    // One shift-add step: the addend is always muxed and always added so every RUN cycle does identical work.
    always_comb begin
        addend    = mult_q[0] ? a_q : '0;
        upper_sum = {1'b0, sum_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        step_sum  = {upper_sum, sum_q[WIDTH-1:1]};
        corr_a    = a_q[WIDTH-1] ? {b_q, {WIDTH{1'b0}}} : '0;
        corr_b    = b_q[WIDTH-1] ? {a_q, {WIDTH{1'b0}}} : '0;
        corr_sum  = sum_q - corr_a - corr_b;
    end

    // Product limb k is tainted once any operand limb at or below k is tainted; a tainted start taints everything.
    always_comb begin
        any_t      = 1'b0;
        limb_taint = '0;
        for (int k = 0; k < NLIMB; k++) begin
            any_t         = any_t | a_t_q[k] | b_t_q[k];
            limb_taint[k] = any_t | ctl_t_q;
        end
        for (int k = NLIMB; k < 2 * NLIMB; k++) begin
            limb_taint[k] = any_t | ctl_t_q;
        end
    end

    // Next-state logic: the sequence depends only on start and the bit counter, never on operand data.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
            S_LOAD:  state_d = S_RUN;
            S_RUN:   if (cnt_q == CW'(WIDTH - 1)) state_d = S_CORR;
            S_CORR:  state_d = S_DONE;
            S_DONE:  state_d = start ? S_LOAD : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next-state: latch on accept, clear in LOAD, step in RUN, publish product and taint in CORR.
    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        mult_d      = mult_q;
        mode_d      = mode_q;
        a_t_d       = a_t_q;
        b_t_d       = b_t_q;
        ctl_t_d     = ctl_t_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        product_d   = product_q;
        product_t_d = product_t_q;
        if (accept) begin
            a_d     = multiplicand;
            b_d     = multiplier;
            mult_d  = multiplier;
            mode_d  = signed_mode;
            a_t_d   = multiplicand_t;
            b_t_d   = multiplier_t;
            ctl_t_d = start_t;
        end
        case (state_q)
            S_LOAD: begin
                sum_d = '0;
                cnt_d = '0;
            end
            S_RUN: begin
                sum_d  = step_sum;
                mult_d = mult_q >> 1;
                cnt_d  = cnt_q + CW'(1);
            end
            S_CORR: begin
                product_d   = mode_q ? corr_sum : sum_q;
                product_t_d = limb_taint;
            end
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and taint registers; reset clears every piece of held data and taint.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q         <= '0;
            b_q         <= '0;
            mult_q      <= '0;
            mode_q      <= 1'b0;
            a_t_q       <= '0;
            b_t_q       <= '0;
            ctl_t_q     <= 1'b0;
            sum_q       <= '0;
            cnt_q       <= '0;
            product_q   <= '0;
            product_t_q <= '0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            mult_q      <= mult_d;
            mode_q      <= mode_d;
            a_t_q       <= a_t_d;
            b_t_q       <= b_t_d;
            ctl_t_q     <= ctl_t_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            product_q   <= product_d;
            product_t_q <= product_t_d;
        end
    end

endmodule

// File: tb/tb_multiplier_taint_track_limb.sv
// tb/tb_multiplier_taint_track_limb.sv - self-checking bench for multiplier_taint_track_limb
module tb_multiplier_taint_track_limb;

    localparam int W  = 8;
    localparam int L  = 4;
    localparam int NL = W / L;
    localparam int LAT = W + 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              start_t;
    logic              signed_mode;
    logic [W-1:0]      multiplicand;
    logic [NL-1:0]     multiplicand_t;
    logic [W-1:0]      multiplier;
    logic [NL-1:0]     multiplier_t;
    logic              ready;
    logic              ready_t;
    logic [2*W-1:0]    product;
    logic [2*NL-1:0]   product_t;
    logic              productDone;
    logic              productDone_t;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [2*W-1:0]  exp_prod;
    logic [2*NL-1:0] exp_pt;
    logic            exp_ctl;

    multiplier_taint_track_limb #(.WIDTH(W), .LIMB(L)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .start_t        (start_t),
        .signed_mode    (signed_mode),
        .multiplicand   (multiplicand),
        .multiplicand_t (multiplicand_t),
        .multiplier     (multiplier),
        .multiplier_t   (multiplier_t),
        .ready          (ready),
        .ready_t        (ready_t),
        .product        (product),
        .product_t      (product_t),
        .productDone    (productDone),
        .productDone_t  (productDone_t)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2*W-1:0] model_product(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
        longint pa, pb, p;
        pa = longint'(a);
        pb = longint'(b);
        if (sm && a[W-1]) pa = pa - (longint'(1) << W);
        if (sm && b[W-1]) pb = pb - (longint'(1) << W);
        p = pa * pb;
        return p[2*W-1:0];
    endfunction

    function automatic logic [2*NL-1:0] model_taint(input logic [NL-1:0] at, input logic [NL-1:0] bt, input logic st);
        int m;
        logic [2*NL-1:0] t;
        if (st) return '1;
        m = 2 * NL;
        for (int i = NL - 1; i >= 0; i--) if (at[i] || bt[i]) m = i;
        t = '0;
        for (int k = 0; k < 2 * NL; k++) t[k] = (k >= m);
        return t;
    endfunction

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic [NL-1:0] at,
                          input logic [NL-1:0] bt, input logic sm, input logic st);
        @(negedge clk);
        multiplicand   = a;
        multiplier     = b;
        multiplicand_t = at;
        multiplier_t   = bt;
        signed_mode    = sm;
        start_t        = st;
        start          = 1'b1;
        exp_prod       = model_product(a, b, sm);
        exp_pt         = model_taint(at, bt, st);
        exp_ctl        = st;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int glitch_at, output int lat);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (glitch_at != 0 && n == glitch_at) begin
                multiplicand   = W'($urandom);
                multiplier     = W'($urandom);
                multiplicand_t = '1;
                multiplier_t   = '1;
                signed_mode    = ~signed_mode;
                start_t        = 1'b1;
                start          = 1'b1;
            end
            if (glitch_at != 0 && n == glitch_at + 1) start = 1'b0;
            if (productDone) begin
                lat = n + 1;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; start_t = 1'b0; signed_mode = 1'b0;
        multiplicand = '0; multiplier = '0; multiplicand_t = '0; multiplier_t = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (product !== '0) begin failures++; $display("FAIL reset_product got=%h exp=0", product); end
        checks++; if (product_t !== '0) begin failures++; $display("FAIL reset_product_t got=%b exp=0", product_t); end
        checks++; if (productDone !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", productDone); end
        checks++; if (productDone_t !== 1'b0) begin failures++; $display("FAIL reset_done_t got=%b exp=0", productDone_t); end
        checks++; if (ready_t !== 1'b0) begin failures++; $display("FAIL reset_ready_t got=%b exp=0", ready_t); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
    endtask

    task automatic test_unsigned_basic();
        int lat;
        launch(8'd13, 8'd11, 2'b00, 2'b00, 1'b0, 1'b0);
        wait_done(0, lat);
        checks++; if (lat !== LAT) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", lat, LAT); end
        checks++; if (product !== 16'h008F) begin failures++; $display("FAIL basic_product got=%h exp=008f", product); end
        checks++; if (product_t !== 4'b0000) begin failures++; $display("FAIL basic_product_t got=%b exp=0000", product_t); end
        checks++; if (productDone_t !== 1'b0) begin failures++; $display("FAIL basic_done_t got=%b exp=0", productDone_t); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL basic_ready_in_done got=%b exp=1", ready); end
        @(posedge clk);
        #1;
        checks++; if (productDone !== 1'b0) begin failures++; $display("FAIL basic_done_single got=%b exp=0", productDone); end
        checks++; if (product !== 16'h008F) begin failures++; $display("FAIL basic_product_held got=%h exp=008f", product); end
    endtask

    task automatic test_signed_mode();
        int lat;
        launch(8'hFD, 8'h05, 2'b00, 2'b00, 1'b1, 1'b0);
        wait_done(0, lat);
        checks++; if (lat !== LAT) begin failures++; $display("FAIL signed_latency got=%0d exp=%0d", lat, LAT); end
        checks++; if (product !== 16'hFFF1) begin failures++; $display("FAIL signed_product got=%h exp=fff1", product); end
        launch(8'hFD, 8'h05, 2'b00, 2'b00, 1'b0, 1'b0);
        wait_done(0, lat);
        checks++; if (lat !== LAT) begin failures++; $display("FAIL unsigned_latency got=%0d exp=%0d", lat, LAT); end
        checks++; if (product !== 16'h04F1) begin failures++; $display("FAIL unsigned_product got=%h exp=04f1", product); end
        launch(8'h80, 8'h80, 2'b00, 2'b00, 1'b1, 1'b0);
        wait_done(0, lat);
        checks++; if (product !== 16'h4000) begin failures++; $display("FAIL signed_minmin got=%h exp=4000", product); end
    endtask

    task automatic test_limb_taint();
        int lat;
        launch(8'h3C, 8'h02, 2'b10, 2'b00, 1'b0, 1'b0);
        wait_done(0, lat);
        checks++; if (product !== 16'h0078) begin failures++; $display("FAIL taint_product got=%h exp=0078", product); end
        checks++; if (product_t !== 4'b1110) begin failures++; $display("FAIL taint_hi_limb got=%b exp=1110", product_t); end
        checks++; if (productDone_t !== 1'b0) begin failures++; $display("FAIL taint_no_ctl got=%b exp=0", productDone_t); end
        launch(8'h3C, 8'h02, 2'b10, 2'b01, 1'b0, 1'b0);
        wait_done(0, lat);
        checks++; if (product_t !== 4'b1111) begin failures++; $display("FAIL taint_lo_limb got=%b exp=1111", product_t); end
    endtask

    task automatic test_start_taint();
        int lat;
        logic [W-1:0] a, b;
        a = W'($urandom); b = W'($urandom);
        launch(a, b, 2'b00, 2'b00, 1'b0, 1'b1);
        wait_done(0, lat);
        checks++; if (product_t !== 4'b1111) begin failures++; $display("FAIL st_product_t got=%b exp=1111", product_t); end
        checks++; if (productDone_t !== 1'b1) begin failures++; $display("FAIL st_done_t got=%b exp=1", productDone_t); end
        checks++; if (ready_t !== 1'b1) begin failures++; $display("FAIL st_ready_t got=%b exp=1", ready_t); end
        checks++; if (product !== exp_prod) begin failures++; $display("FAIL st_product got=%h exp=%h", product, exp_prod); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ready_t !== 1'b1) begin failures++; $display("FAIL st_ready_t_sticky got=%b exp=1", ready_t); end
        a = W'($urandom); b = W'($urandom);
        launch(a, b, 2'b00, 2'b00, 1'b0, 1'b0);
        wait_done(0, lat);
        checks++; if (product_t !== 4'b0000) begin failures++; $display("FAIL reconv_product_t got=%b exp=0000", product_t); end
        checks++; if (productDone_t !== 1'b0) begin failures++; $display("FAIL reconv_done_t got=%b exp=0", productDone_t); end
        checks++; if (ready_t !== 1'b0) begin failures++; $display("FAIL reconv_ready_t got=%b exp=0", ready_t); end
        checks++; if (product !== exp_prod) begin failures++; $display("FAIL reconv_product got=%h exp=%h", product, exp_prod); end
    endtask

    task automatic test_back_to_back();
        int lat, t_prev;
        launch(W'($urandom), W'($urandom), NL'($urandom), NL'($urandom), 1'($urandom), 1'b0);
        wait_done(3, lat);
        t_prev = cyc;
        checks++; if (product !== exp_prod) begin failures++; $display("FAIL b2b0_product got=%h exp=%h", product, exp_prod); end
        checks++; if (product_t !== exp_pt) begin failures++; $display("FAIL b2b0_product_t got=%b exp=%b", product_t, exp_pt); end
        for (int i = 1; i <= 3; i++) begin
            launch(W'($urandom), W'($urandom), NL'($urandom), NL'($urandom), 1'($urandom), 1'b0);
            wait_done(2 + i, lat);
            checks++; if (cyc - t_prev !== LAT) begin failures++; $display("FAIL b2b%0d_spacing got=%0d exp=%0d", i, cyc - t_prev, LAT); end
            checks++; if (product !== exp_prod) begin failures++; $display("FAIL b2b%0d_product got=%h exp=%h", i, product, exp_prod); end
            checks++; if (product_t !== exp_pt) begin failures++; $display("FAIL b2b%0d_product_t got=%b exp=%b", i, product_t, exp_pt); end
            checks++; if (productDone_t !== 1'b0) begin failures++; $display("FAIL b2b%0d_done_t got=%b exp=0", i, productDone_t); end
            t_prev = cyc;
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        logic seen;
        launch(8'hE7, 8'h9B, 2'b11, 2'b00, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (product !== '0) begin failures++; $display("FAIL abort_product got=%h exp=0", product); end
        checks++; if (product_t !== '0) begin failures++; $display("FAIL abort_product_t got=%b exp=0", product_t); end
        checks++; if (productDone !== 1'b0) begin failures++; $display("FAIL abort_done got=%b exp=0", productDone); end
        checks++; if (productDone_t !== 1'b0) begin failures++; $display("FAIL abort_done_t got=%b exp=0", productDone_t); end
        checks++; if (ready_t !== 1'b0) begin failures++; $display("FAIL abort_ready_t got=%b exp=0", ready_t); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL abort_ready got=%b exp=1", ready); end
        seen = 1'b0;
        for (int n = 0; n < 2 * LAT; n++) begin
            @(posedge clk);
            #1;
            if (productDone) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_done got=%b exp=0", seen); end
        launch(8'hC3, 8'h7E, 2'b00, 2'b10, 1'b1, 1'b0);
        wait_done(0, lat);
        checks++; if (lat !== LAT) begin failures++; $display("FAIL post_abort_latency got=%0d exp=%0d", lat, LAT); end
        checks++; if (product !== exp_prod) begin failures++; $display("FAIL post_abort_product got=%h exp=%h", product, exp_prod); end
        checks++; if (product_t !== exp_pt) begin failures++; $display("FAIL post_abort_product_t got=%b exp=%b", product_t, exp_pt); end
    endtask

    task automatic test_random();
        int lat;
        for (int i = 0; i < 16; i++) begin
            launch(W'($urandom), W'($urandom), NL'($urandom), NL'($urandom), 1'($urandom),
                   ($urandom_range(0, 3) == 0));
            wait_done(0, lat);
            checks++; if (lat !== LAT) begin failures++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, LAT); end
            checks++; if (product !== exp_prod) begin failures++; $display("FAIL rnd%0d_product got=%h exp=%h", i, product, exp_prod); end
            checks++; if (product_t !== exp_pt) begin failures++; $display("FAIL rnd%0d_product_t got=%b exp=%b", i, product_t, exp_pt); end
            checks++; if (productDone_t !== exp_ctl) begin failures++; $display("FAIL rnd%0d_done_t got=%b exp=%b", i, productDone_t, exp_ctl); end
            checks++; if (ready_t !== exp_ctl) begin failures++; $display("FAIL rnd%0d_ready_t got=%b exp=%b", i, ready_t, exp_ctl); end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_basic();
        test_signed_mode();
        test_limb_taint();
        test_start_taint();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
